// File: rtl/serial_detect_pkg.sv
// Shared types and helpers for the serial detector scheduler.
package serial_detect_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Round-robin pick: a lone request wins; on a tie the one not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_served);
        logic [1:0] pick;
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (last_served == REQ1) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/serial_detect_sched_piso.sv
// Parallel-load, MSB-first shift register with a down-counting bit index.
module piso_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out,
    output logic             last_bit
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load) begin
            sreg_d = din;
            cnt_d  = CW'(WIDTH - 1);
        end else if (shift) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_out  = sreg_q[WIDTH-1];
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/serial_detect_sched.sv
// Round-robin scheduler sharing one bit-serial sequence detector between two requesters.
module serial_detect_sched
    import serial_detect_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             hit_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             det_clear,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  hit_count
);
    sched_state_t    state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            last_served_q, last_served_d;
    logic [CNTW-1:0] hit_count_q, hit_count_d;
    logic            skip_q, skip_d;
    logic            bit_out, last_bit;
    logic [WIDTH-1:0] word;

    assign word = grant_q[REQ1] ? data1 : data0;

    piso_shifter #(.WIDTH(WIDTH)) u_piso (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q == LOAD),
        .shift    (state_q == SHIFT),
        .din      (word),
        .bit_out  (bit_out),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        hit_count_d   = hit_count_q;
        skip_d        = skip_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = rr_pick(req, last_served_q);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                last_served_d = grant_q[REQ1] ? REQ1 : REQ0;
                hit_count_d   = '0;
                skip_d        = 1'b1;
                state_d       = SHIFT;
            end
            SHIFT: begin
                // The detector is Moore, so the sample in the first bit cycle predates the word.
                skip_d = 1'b0;
                if (!skip_q && hit_in) hit_count_d = hit_count_q + CNTW'(1);
                if (last_bit) state_d = DRAIN;
            end
            DRAIN: begin
                if (hit_in) hit_count_d = hit_count_q + CNTW'(1);
                state_d = DONE;
            end
            DONE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_served_q <= REQ1;
            hit_count_q   <= '0;
            skip_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            hit_count_q   <= hit_count_d;
            skip_q        <= skip_d;
        end
    end

    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = (state_q == SHIFT) & bit_out;
    assign det_clear    = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign grant        = grant_q;
    assign hit_count    = hit_count_q;

endmodule

// File: tb/tb_serial_detect_sched.sv
// Directed bench for serial_detect_sched with WIDTH=8.
module tb_serial_detect_sched;
    localparam int W = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [W-1:0]  data0, data1;
    logic          hit_in;
    logic          serial_out, serial_valid, det_clear, busy, done;
    logic [1:0]    grant;
    logic [CW-1:0] hit_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    serial_detect_sched #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .data0        (data0),
        .data1        (data1),
        .hit_in       (hit_in),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .det_clear    (det_clear),
        .grant        (grant),
        .busy         (busy),
        .done         (done),
        .hit_count    (hit_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0; hit_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        obs = {serial_out, serial_valid, det_clear, grant, busy, done, 1'b0};
        n_total++;
        if (obs !== 8'h00 || hit_count !== 4'd0) begin
            $display("FAIL reset_outputs: got flags=%b cnt=%0d want flags=00000000 cnt=0", obs, hit_count);
        end else n_pass++;
    endtask

    // Called in an IDLE cycle; drives one request through to the following IDLE cycle.
    // hits[k] is hit_in during SHIFT cycle k, hd is hit_in during DRAIN.
    task automatic do_txn(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] hits, input logic hd, input logic [1:0] eg,
                          input logic [W-1:0] ew, input logic [CW-1:0] ecnt, input logic drop,
                          input string nm);
        logic [1:0] x_grant;
        logic       x_valid, x_sout, x_busy, x_done, x_clr;
        req = r; data0 = d0; data1 = d1; hit_in = 1'b0;
        for (int c = 1; c <= W + 4; c++) begin
            tick();
            if (drop && c == 1) req = 2'b00;
            if (drop && c == 2) begin data0 = ~d0; data1 = ~d1; end
            if (c >= 2 && c <= W + 1) hit_in = hits[c-2];
            else if (c == W + 2)      hit_in = hd;
            else                      hit_in = 1'b0;
            x_busy  = (c <= W + 3);
            x_grant = x_busy ? eg : 2'b00;
            x_clr   = (c == 1);
            x_valid = (c >= 2 && c <= W + 1);
            x_sout  = x_valid ? ew[W-1-(c-2)] : 1'b0;
            x_done  = (c == W + 3);
            n_total++;
            if (grant !== x_grant || busy !== x_busy || det_clear !== x_clr ||
                serial_valid !== x_valid || serial_out !== x_sout || done !== x_done) begin
                $display("FAIL %s cycle t+%0d: got g=%b b=%b clr=%b v=%b so=%b d=%b want g=%b b=%b clr=%b v=%b so=%b d=%b",
                         nm, c, grant, busy, det_clear, serial_valid, serial_out, done,
                         x_grant, x_busy, x_clr, x_valid, x_sout, x_done);
            end else n_pass++;
            if (c == W + 3 || c == W + 4) begin
                n_total++;
                if (hit_count !== ecnt)
                    $display("FAIL %s hit_count t+%0d: got %0d want %0d", nm, c, hit_count, ecnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_basic();
        do_txn(2'b01, 8'b1011_0110, 8'h00, 8'h00, 1'b0, 2'b01, 8'b1011_0110, 4'd0, 1'b0, "basic_req0");
        req = 2'b00;
        tick();
    endtask

    task automatic test_all_hits();
        do_txn(2'b10, 8'h11, 8'h5A, 8'hFF, 1'b1, 2'b10, 8'h5A, 4'd8, 1'b0, "all_hits_req1");
        req = 2'b00;
        tick();
    endtask

    task automatic test_edge_samples();
        do_txn(2'b01, 8'hC3, 8'h00, 8'b0000_0001, 1'b1, 2'b01, 8'hC3, 4'd1, 1'b0, "cycle0_and_drain");
        req = 2'b00;
        tick();
        do_txn(2'b10, 8'h00, 8'h96, 8'b1010_1010, 1'b0, 2'b10, 8'h96, 4'd4, 1'b0, "alt_hits");
        req = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        test_reset();
        do_txn(2'b11, 8'hA5, 8'h3C, 8'h00, 1'b1, 2'b01, 8'hA5, 4'd1, 1'b0, "b2b_first");
        do_txn(2'b11, 8'hA5, 8'h3C, 8'h06, 1'b0, 2'b10, 8'h3C, 4'd2, 1'b0, "b2b_second");
        do_txn(2'b11, 8'hA5, 8'h3C, 8'h00, 1'b0, 2'b01, 8'hA5, 4'd0, 1'b0, "b2b_third");
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs;
        req = 2'b01; data0 = 8'hFF; hit_in = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            req = 2'b00;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hit_in = 1'b0;
        obs = {serial_out, serial_valid, det_clear, grant, busy, done, 1'b0};
        n_total++;
        if (obs !== 8'h00 || hit_count !== 4'd0)
            $display("FAIL reset_mid_outputs: got flags=%b cnt=%0d want flags=00000000 cnt=0", obs, hit_count);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_mid_idle: got done=%b busy=%b want 0 0", done, busy);
            else n_pass++;
        end
        do_txn(2'b01, 8'h81, 8'h00, 8'h80, 1'b0, 2'b01, 8'h81, 4'd1, 1'b0, "after_reset");
        req = 2'b00;
        tick();
    endtask

    task automatic test_pulse_req();
        do_txn(2'b01, 8'h3C, 8'h00, 8'h00, 1'b0, 2'b01, 8'h3C, 4'd0, 1'b1, "pulse_req_capture");
        tick();
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL pulse_req_no_retrigger: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_hits();
        test_edge_samples();
        test_back_to_back();
        test_reset_mid();
        test_pulse_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_detect_sched.md
# serial_detect_sched

- Round-robin scheduler that lets two requesters share one bit-serial sequence detector (an `Input`/`Prob2` style FSM).
- For each granted request it captures a parallel word, clears the detector, and shifts the word MSB-first into the detector.
- It counts detector hits over that word and returns the count with a one-cycle `done` pulse.
- It sits between the requester logic and the shared detector instance.

## Interface

Parameters:
- `WIDTH`, default 8: bits per serialized word; WIDTH ≥ 2.
- `CNTW`, default `$clog2(WIDTH+1)`: width of the hit counter.

Ports:
- `clock`  in  1: single system clock, all logic on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  2: per-requester request, level; bit i = requester i.
- `data0`  in  WIDTH: word of requester 0, sampled in LOAD.
- `data1`  in  WIDTH: word of requester 1, sampled in LOAD.
- `hit_in`  in  1: detector output (Moore; reflects bits applied up to the previous cycle).
- `serial_out`  out  1: bit driven into the detector input.
- `serial_valid`  out  1: high while `serial_out` carries a word bit.
- `det_clear`  out  1: one-cycle clear for the detector, tied to the detector's reset.
- `grant`  out  2: one-hot owner of the current transaction, 00 when idle.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse marking the end of a transaction.
- `hit_count`  out  CNTW: hits for the last completed word, held until the next LOAD.

## Operation

States: IDLE, LOAD, SHIFT, DRAIN, DONE.

- **IDLE**
  - If `req`≠00, arbitrate and go to LOAD; otherwise stay.
  - Arbitration: a single request wins; if both request, grant the requester not in `last_served`.
- **LOAD** (1 cycle)
  - `grant` is one-hot; the granted word goes into the shift register.
  - `det_clear`=1, the hit counter is zeroed, `last_served` is updated; go to SHIFT.
- **SHIFT** (exactly WIDTH cycles)
  - Cycle k (0..WIDTH-1): `serial_out` = word[WIDTH-1-k], `serial_valid`=1.
  - `hit_in` is sampled in SHIFT cycles 1..WIDTH-1; the counter increments when `hit_in`=1.
  - After cycle WIDTH-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - `serial_valid`=0, `serial_out`=0.
  - `hit_in` is sampled once more, for the response to the last bit; go to DONE.
- **DONE** (1 cycle)
  - `done`=1, `grant` still asserted, `hit_count` final; go to IDLE.
- **Counting and width rules**
  - Exactly WIDTH samples of `hit_in` per word, so `hit_count` ≤ WIDTH and never wraps.
  - The counter width is CNTW.
- **Request handling**
  - `req` is ignored outside IDLE.
  - A requester may drop `req` after grant; the transaction still completes.
  - `data0`/`data1` matter only in the LOAD cycle.
- **Back-to-back requests**
  - A `req` still high during DONE is seen in the following IDLE cycle.
  - So there is a 1-cycle minimum gap between transactions.
  - With both requesters continuously requesting, grants alternate 0,1,0,1…

## Timing

- Reset values: state IDLE, `last_served`=1 (requester 0 wins the first tie), and all outputs 0.
  - That is `serial_out`, `serial_valid`, `det_clear`, `grant`, `busy`, `done` and `hit_count`.
- Reset mid-transaction aborts it: no `done`, `hit_count` returns to 0, IDLE on the next cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `req`/`hit_in` to any output.
- Latency, with `req` sampled high in IDLE at cycle t:
  - LOAD at t+1;
  - SHIFT at t+2..t+WIDTH+1;
  - DRAIN at t+WIDTH+2;
  - DONE at t+WIDTH+3;
  - IDLE at t+WIDTH+4.
- `det_clear` is asserted in the cycle before the first serial bit, so the detector starts each word from its reset state.

## Structure

- Package `serial_detect_pkg` holds:
  - the state enum `sched_state_t` {IDLE, LOAD, SHIFT, DRAIN, DONE};
  - requester index constants `REQ0`=0, `REQ1`=1.
- Sub-module `piso_shifter`:
  - WIDTH-bit parallel-load, MSB-first shift register with bit index counter;
  - inputs load/shift; outputs `bit_out` and `last_bit`.
  - The scheduler FSM, arbiter and hit counter live in the top module.

## Test plan

- Reset, then `req`=01, `data0`=8'b1011_0110, `hit_in`=0:
  - `serial_out` sequence 1,0,1,1,0,1,1,0 in cycles t+2..t+9;
  - `done` at t+11, `hit_count`=0, `grant`=01 in t+1..t+11.
- `req`=10 with `hit_in` held 1 -> `hit_count`=8, `grant`=10, `done` pulse exactly one cycle.
- `hit_in`=1 only in SHIFT cycle 0 and in DRAIN -> `hit_count`=1 (cycle 0 not counted, DRAIN counted).
- `req`=11 held for 3 transactions after reset -> grant order 01,10,01; one IDLE cycle between each DONE and the next LOAD.
- `reset` asserted during SHIFT cycle 4 -> next cycle all outputs 0, no `done`; a following `req`=01 gets the normal t+WIDTH+3 latency.
- `req` pulsed for one IDLE cycle only, with `data0` changed after LOAD -> the transaction completes using the value captured in LOAD.
